// File: rtl/rv32_ex_top_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv32_ex_top_pkg
// Purpose  : Shared constants for the RV32 execute stage: opcodes, ALU and
//            M-extension funct3 codes, the NOP word and the mul/div state
//            encoding.
// Revision : 1.0 - initial release
// ============================================================================
package rv32_ex_top_pkg;

    // Major opcodes (iw[6:0])
    localparam logic [6:0] C_OPC_OP     = 7'b0110011;
    localparam logic [6:0] C_OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] C_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] C_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] C_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] C_OPC_JALR   = 7'b1100111;
    localparam logic [6:0] C_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] C_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] C_OPC_BRANCH = 7'b1100011;

    // funct7 value that marks an M-extension instruction under C_OPC_OP
    localparam logic [6:0] C_F7_MULDIV  = 7'b0000001;

    // ALU funct3 codes
    localparam logic [2:0] C_F3_ADD  = 3'b000;
    localparam logic [2:0] C_F3_SLL  = 3'b001;
    localparam logic [2:0] C_F3_SLT  = 3'b010;
    localparam logic [2:0] C_F3_SLTU = 3'b011;
    localparam logic [2:0] C_F3_XOR  = 3'b100;
    localparam logic [2:0] C_F3_SR   = 3'b101;
    localparam logic [2:0] C_F3_OR   = 3'b110;
    localparam logic [2:0] C_F3_AND  = 3'b111;

    // M-extension funct3 codes
    localparam logic [2:0] C_M_MUL    = 3'b000;
    localparam logic [2:0] C_M_MULH   = 3'b001;
    localparam logic [2:0] C_M_MULHSU = 3'b010;
    localparam logic [2:0] C_M_MULHU  = 3'b011;
    localparam logic [2:0] C_M_DIV    = 3'b100;
    localparam logic [2:0] C_M_DIVU   = 3'b101;
    localparam logic [2:0] C_M_REM    = 3'b110;
    localparam logic [2:0] C_M_REMU   = 3'b111;

    // Canonical bubble: ADDI x0,x0,0
    localparam logic [31:0] C_NOP = 32'h0000_0013;

    // Mul/div state encoding
    localparam int         C_ST_W    = 2;
    localparam logic [1:0] C_ST_IDLE = 2'd0;
    localparam logic [1:0] C_ST_BUSY = 2'd1;
    localparam logic [1:0] C_ST_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/rv32_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : rv32_muldiv
// Purpose  : Iterative RV32M multiply/divide. Radix-2 shift-add multiply and
//            restoring divide on operand magnitudes, 32 iterations, with the
//            sign applied after the last iteration. Built only when RV32M_EN
//            is defined.
// Revision : 1.0 - initial release
// ============================================================================
`ifdef RV32M_EN
module rv32_muldiv
    import rv32_ex_top_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    logic [C_ST_W-1:0] r_state;
    logic [C_ST_W-1:0] w_state_nxt;
    logic [4:0]        r_cnt;
    logic [2:0]        r_op;
    logic [31:0]       r_a_orig;
    logic [31:0]       r_b_mag;
    logic [31:0]       r_hi;
    logic [31:0]       r_lo;
    logic              r_neg_q;
    logic              r_neg_r;
    logic              r_div0;

    logic              w_a_signed;
    logic              w_b_signed;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [31:0]       w_a_mag;
    logic [31:0]       w_b_mag;
    logic [32:0]       w_mul_sum;
    logic [32:0]       w_div_shift;
    logic [32:0]       w_div_diff;
    logic [63:0]       w_prod;
    logic [31:0]       w_quo;
    logic [31:0]       w_rem;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= C_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: IDLE -> BUSY on start, BUSY for 32 iterations, DONE for one cycle
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            C_ST_IDLE: if (start)          w_state_nxt = C_ST_BUSY;
            C_ST_BUSY: if (r_cnt == 5'd31) w_state_nxt = C_ST_DONE;
            C_ST_DONE:                     w_state_nxt = C_ST_IDLE;
            default:                       w_state_nxt = C_ST_IDLE;
        endcase
    end

    // State outputs
    always_comb begin
        busy = (r_state == C_ST_BUSY);
        done = (r_state == C_ST_DONE);
    end

    // Operand signedness and magnitudes at start
    always_comb begin
        w_a_signed = (op == C_M_MULH) || (op == C_M_MULHSU) ||
                     (op == C_M_DIV)  || (op == C_M_REM);
        w_b_signed = (op == C_M_MULH) || (op == C_M_DIV) || (op == C_M_REM);
        w_a_neg    = w_a_signed & a[31];
        w_b_neg    = w_b_signed & b[31];
        w_a_mag    = w_a_neg ? -a : a;
        w_b_mag    = w_b_neg ? -b : b;
    end

    // One iteration: multiply adds then shifts right, divide shifts left then trial-subtracts
    always_comb begin
        w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b_mag} : 33'd0);
        w_div_shift = {r_hi, r_lo[31]};
        w_div_diff  = w_div_shift - {1'b0, r_b_mag};
    end

    // Operand latch and iteration datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= 5'd0;
            r_op     <= 3'd0;
            r_a_orig <= 32'd0;
            r_b_mag  <= 32'd0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
        end else if (r_state == C_ST_IDLE && start) begin
            r_cnt    <= 5'd0;
            r_op     <= op;
            r_a_orig <= a;
            r_b_mag  <= w_b_mag;
            r_hi     <= 32'd0;
            r_lo     <= w_a_mag;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_div0   <= (b == 32'd0);
        end else if (r_state == C_ST_BUSY) begin
            r_cnt <= r_cnt + 5'd1;
            if (r_op[2]) begin
                if (!w_div_diff[32]) begin
                    r_hi <= w_div_diff[31:0];
                    r_lo <= {r_lo[30:0], 1'b1};
                end else begin
                    r_hi <= w_div_shift[31:0];
                    r_lo <= {r_lo[30:0], 1'b0};
                end
            end else begin
                r_hi <= w_mul_sum[32:1];
                r_lo <= {w_mul_sum[0], r_lo[31:1]};
            end
        end
    end

    // Sign fix-up and result select after the final iteration
    always_comb begin
        w_prod = r_neg_q ? -{r_hi, r_lo} : {r_hi, r_lo};
        w_quo  = r_neg_q ? -r_lo : r_lo;
        w_rem  = r_neg_r ? -r_hi : r_hi;
        case (r_op)
            C_M_MUL:                       result = w_prod[31:0];
            C_M_MULH, C_M_MULHSU, C_M_MULHU: result = w_prod[63:32];
            C_M_DIV, C_M_DIVU:             result = r_div0 ? 32'hFFFF_FFFF : w_quo;
            default:                       result = r_div0 ? r_a_orig : w_rem;
        endcase
    end

endmodule
`endif
`default_nettype wire

// File: rtl/rv32_ex_top.sv
`default_nettype none
// ============================================================================
// Module   : rv32_ex_top
// Purpose  : RV32I execute stage with EX/MEM pipeline register and
//            same-cycle forwarding to ID. Optional iterative M extension
//            enabled by the RV32M_EN macro; without it M-ops pass as bubbles.
// Revision : 1.0 - initial release
// ============================================================================
module rv32_ex_top
    import rv32_ex_top_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_in,
    input  logic [31:0] iw_in,
    input  logic [31:0] rs1_data_in,
    input  logic [31:0] rs2_data_in,
    input  logic [4:0]  wb_reg_in,
    input  logic        wb_enable_in,
    output logic [31:0] pc_out,
    output logic [31:0] iw_out,
    output logic [31:0] alu_out,
    output logic [4:0]  wb_reg_out,
    output logic        wb_enable_out,
    output logic [31:0] rs2_data_out,
    output logic        store_out,
    output logic        df_ex_enable,
    output logic [4:0]  df_ex_reg,
    output logic [31:0] df_ex_data,
    output logic        ex_stall
);

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic        w_is_mop;
    logic        w_is_load;
    logic        w_is_store;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_u;
    logic [31:0] w_opb;
    logic [4:0]  w_shamt;
    logic [31:0] w_arith;
    logic [31:0] w_alu;
    logic        w_stall;
    logic        w_mop_ready;
    logic [31:0] w_mop_result;
    logic [31:0] w_result;
    logic        w_wb_en;

    assign w_opcode   = iw_in[6:0];
    assign w_funct3   = iw_in[14:12];
    assign w_funct7   = iw_in[31:25];
    assign w_is_mop   = (w_opcode == C_OPC_OP) && (w_funct7 == C_F7_MULDIV);
    assign w_is_load  = (w_opcode == C_OPC_LOAD);
    assign w_is_store = (w_opcode == C_OPC_STORE);

    // Immediate decode and RV32I ALU
    always_comb begin
        w_imm_i = {{20{iw_in[31]}}, iw_in[31:20]};
        w_imm_s = {{20{iw_in[31]}}, iw_in[31:25], iw_in[11:7]};
        w_imm_u = {iw_in[31:12], 12'd0};
        w_opb   = (w_opcode == C_OPC_OP) ? rs2_data_in : w_imm_i;
        w_shamt = w_opb[4:0];
        case (w_funct3)
            C_F3_ADD:  w_arith = ((w_opcode == C_OPC_OP) && iw_in[30]) ?
                                 rs1_data_in - w_opb : rs1_data_in + w_opb;
            C_F3_SLL:  w_arith = rs1_data_in << w_shamt;
            C_F3_SLT:  w_arith = {31'd0, $signed(rs1_data_in) < $signed(w_opb)};
            C_F3_SLTU: w_arith = {31'd0, rs1_data_in < w_opb};
            C_F3_XOR:  w_arith = rs1_data_in ^ w_opb;
            C_F3_SR:   w_arith = iw_in[30] ? $unsigned($signed(rs1_data_in) >>> w_shamt)
                                           : rs1_data_in >> w_shamt;
            C_F3_OR:   w_arith = rs1_data_in | w_opb;
            default:   w_arith = rs1_data_in & w_opb;
        endcase
        case (w_opcode)
            C_OPC_OP, C_OPC_OP_IMM: w_alu = w_arith;
            C_OPC_LUI:              w_alu = w_imm_u;
            C_OPC_AUIPC:            w_alu = pc_in + w_imm_u;
            C_OPC_JAL, C_OPC_JALR:  w_alu = pc_in + 32'd4;
            C_OPC_LOAD:             w_alu = rs1_data_in + w_imm_i;
            C_OPC_STORE:            w_alu = rs1_data_in + w_imm_s;
            default:                w_alu = 32'd0;
        endcase
    end

`ifdef RV32M_EN
    logic        w_md_busy;
    logic        w_md_done;
    logic [31:0] w_md_result;

    rv32_muldiv u_muldiv (
        .clk    (clk),
        .reset  (reset),
        .start  (w_is_mop),
        .op     (w_funct3),
        .a      (rs1_data_in),
        .b      (rs2_data_in),
        .busy   (w_md_busy),
        .done   (w_md_done),
        .result (w_md_result)
    );

    // Hold upstream from the cycle an M-op arrives until its result is ready
    assign w_stall      = w_is_mop & (w_md_busy | ~w_md_done);
    assign w_mop_ready  = w_md_done;
    assign w_mop_result = w_md_result;
`else
    assign w_stall      = 1'b0;
    assign w_mop_ready  = 1'b0;
    assign w_mop_result = 32'd0;
`endif

    assign w_result = w_is_mop ? (w_mop_ready ? w_mop_result : 32'd0) : w_alu;
    assign w_wb_en  = wb_enable_in & (~w_is_mop | w_mop_ready);

    // Forwarding to ID: load data is not known here, and an M-op only once done
    assign df_ex_enable = w_wb_en & ~w_is_load;
    assign df_ex_reg    = wb_reg_in;
    assign df_ex_data   = w_result;
    assign ex_stall     = w_stall;

    // EX/MEM register; a stall cycle inserts a bubble so no partial result leaves
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_out        <= 32'd0;
            iw_out        <= C_NOP;
            alu_out       <= 32'd0;
            wb_reg_out    <= 5'd0;
            wb_enable_out <= 1'b0;
            rs2_data_out  <= 32'd0;
            store_out     <= 1'b0;
        end else if (w_stall) begin
            pc_out        <= pc_in;
            iw_out        <= C_NOP;
            alu_out       <= 32'd0;
            wb_reg_out    <= 5'd0;
            wb_enable_out <= 1'b0;
            rs2_data_out  <= 32'd0;
            store_out     <= 1'b0;
        end else begin
            pc_out        <= pc_in;
            iw_out        <= iw_in;
            alu_out       <= w_result;
            wb_reg_out    <= wb_reg_in;
            wb_enable_out <= w_wb_en;
            rs2_data_out  <= rs2_data_in;
            store_out     <= w_is_store;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rv32_ex_top.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv32_ex_top
// Purpose  : Directed-vector bench for rv32_ex_top with hand-computed
//            expected values. M-extension vectors are exercised when
//            RV32M_EN is defined; otherwise M-op pass-through is checked.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv32_ex_top;

    localparam logic [31:0] C_TB_NOP = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic [31:0] pc_in;
    logic [31:0] iw_in;
    logic [31:0] rs1_data_in;
    logic [31:0] rs2_data_in;
    logic [4:0]  wb_reg_in;
    logic        wb_enable_in;
    logic [31:0] pc_out;
    logic [31:0] iw_out;
    logic [31:0] alu_out;
    logic [4:0]  wb_reg_out;
    logic        wb_enable_out;
    logic [31:0] rs2_data_out;
    logic        store_out;
    logic        df_ex_enable;
    logic [4:0]  df_ex_reg;
    logic [31:0] df_ex_data;
    logic        ex_stall;

    int n_vec = 0;
    int n_err = 0;

    rv32_ex_top dut (
        .clk           (clk),
        .reset         (reset),
        .pc_in         (pc_in),
        .iw_in         (iw_in),
        .rs1_data_in   (rs1_data_in),
        .rs2_data_in   (rs2_data_in),
        .wb_reg_in     (wb_reg_in),
        .wb_enable_in  (wb_enable_in),
        .pc_out        (pc_out),
        .iw_out        (iw_out),
        .alu_out       (alu_out),
        .wb_reg_out    (wb_reg_out),
        .wb_enable_out (wb_enable_out),
        .rs2_data_out  (rs2_data_out),
        .store_out     (store_out),
        .df_ex_enable  (df_ex_enable),
        .df_ex_reg     (df_ex_reg),
        .df_ex_data    (df_ex_data),
        .ex_stall      (ex_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic [31:0] pc, input logic [31:0] iw,
                         input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [4:0] rd, input logic we);
        pc_in        = pc;
        iw_in        = iw;
        rs1_data_in  = rs1;
        rs2_data_in  = rs2;
        wb_reg_in    = rd;
        wb_enable_in = we;
    endtask

    // Single-cycle instruction: forwarded value now, registered value one edge later
    task automatic alu_vec(input string tag, input logic [31:0] iw, input logic [31:0] pc,
                           input logic [31:0] rs1, input logic [31:0] rs2,
                           input logic [31:0] exp);
        apply(pc, iw, rs1, rs2, 5'd3, 1'b1);
        #1;
        check({tag, " df_data"}, df_ex_data, exp);
        step();
        check({tag, " alu_out"}, alu_out, exp);
    endtask

`ifdef RV32M_EN
    // M-op: 33 stall cycles each producing a bubble, then the result one edge later
    task automatic mop_vec(input string tag, input logic [31:0] iw,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp);
        apply(32'h300, iw, a, b, 5'd3, 1'b1);
        #1;
        for (int i = 0; i < 33; i++) begin
            check({tag, " stall"}, {31'd0, ex_stall}, 32'd1);
            step();
            check({tag, " bubble_iw"}, iw_out, C_TB_NOP);
            check({tag, " bubble_alu"}, alu_out, 32'd0);
        end
        check({tag, " stall_end"}, {31'd0, ex_stall}, 32'd0);
        check({tag, " df_data"}, df_ex_data, exp);
        step();
        check({tag, " result"}, alu_out, exp);
        check({tag, " iw_out"}, iw_out, iw);
        check({tag, " wb_en"}, {31'd0, wb_enable_out}, 32'd1);
        apply(32'h304, C_TB_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
    endtask
`endif

    initial begin
        apply(32'd0, C_TB_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
        reset = 1'b1;
        step();
        step();
        // Reset state
        check("rst pc_out", pc_out, 32'd0);
        check("rst iw_out", iw_out, C_TB_NOP);
        check("rst alu_out", alu_out, 32'd0);
        check("rst wb_reg_out", {27'd0, wb_reg_out}, 32'd0);
        check("rst wb_en", {31'd0, wb_enable_out}, 32'd0);
        check("rst rs2_out", rs2_data_out, 32'd0);
        check("rst store", {31'd0, store_out}, 32'd0);
        check("rst stall", {31'd0, ex_stall}, 32'd0);
        reset = 1'b0;

        // ADDI x5,x0,-1
        apply(32'h100, 32'hFFF0_0293, 32'd0, 32'd0, 5'd5, 1'b1);
        #1;
        check("addi df_en", {31'd0, df_ex_enable}, 32'd1);
        check("addi df_reg", {27'd0, df_ex_reg}, 32'd5);
        check("addi df_data", df_ex_data, 32'hFFFF_FFFF);
        step();
        check("addi alu_out", alu_out, 32'hFFFF_FFFF);
        check("addi pc_out", pc_out, 32'h100);
        check("addi wb_reg", {27'd0, wb_reg_out}, 32'd5);

        // SW x2,8(x1)
        apply(32'h104, 32'h0020_A423, 32'h0000_1000, 32'hCAFE_BABE, 5'd8, 1'b0);
        step();
        check("sw alu_out", alu_out, 32'h0000_1008);
        check("sw store", {31'd0, store_out}, 32'd1);
        check("sw rs2_out", rs2_data_out, 32'hCAFE_BABE);
        check("sw wb_en", {31'd0, wb_enable_out}, 32'd0);

        alu_vec("add",  32'h0020_81B3, 32'h0, 32'd5, 32'd7, 32'd12);
        check("add store", {31'd0, store_out}, 32'd0);
        alu_vec("sub",  32'h4020_81B3, 32'h0, 32'd5, 32'd7, 32'hFFFF_FFFE);
        alu_vec("slt",  32'h0020_A1B3, 32'h0, 32'hFFFF_FFFF, 32'd1, 32'd1);
        alu_vec("sltu", 32'h0020_B1B3, 32'h0, 32'hFFFF_FFFF, 32'd1, 32'd0);
        alu_vec("sra",  32'h4020_D1B3, 32'h0, 32'h8000_0000, 32'h24, 32'hF800_0000);
        alu_vec("srli", 32'h0040_D193, 32'h0, 32'h8000_0000, 32'd0, 32'h0800_0000);
        alu_vec("lui",  32'h1234_51B7, 32'h0, 32'd0, 32'd0, 32'h1234_5000);
        alu_vec("auipc", 32'h0000_1197, 32'h100, 32'd0, 32'd0, 32'h0000_1100);
        alu_vec("jal",  32'h0080_00EF, 32'h200, 32'd0, 32'd0, 32'h0000_0204);
        alu_vec("beq",  32'h0020_8463, 32'h200, 32'd9, 32'd9, 32'd0);

        // LW x3,4(x1): address computed, no forwarding
        apply(32'h208, 32'h0040_A183, 32'h0000_2000, 32'd0, 5'd3, 1'b1);
        #1;
        check("lw df_en", {31'd0, df_ex_enable}, 32'd0);
        step();
        check("lw alu_out", alu_out, 32'h0000_2004);
        check("lw wb_en", {31'd0, wb_enable_out}, 32'd1);

`ifdef RV32M_EN
        mop_vec("mul",   32'h0220_81B3, 32'h0001_0000, 32'h0001_0000, 32'd0);
        mop_vec("mulhu", 32'h0220_B1B3, 32'h0001_0000, 32'h0001_0000, 32'd1);
        mop_vec("mulh",  32'h0220_91B3, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);
        mop_vec("div",   32'h0220_C1B3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        mop_vec("rem",   32'h0220_E1B3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        mop_vec("div0",  32'h0220_C1B3, 32'd5, 32'd0, 32'hFFFF_FFFF);
        mop_vec("rem0",  32'h0220_E1B3, 32'd5, 32'd0, 32'd5);
        mop_vec("divov", 32'h0220_C1B3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        mop_vec("divu",  32'h0220_D1B3, 32'd100, 32'd7, 32'd14);

        // Reset during BUSY cycle 10 of a DIV
        apply(32'h400, 32'h0220_C1B3, 32'd100, 32'd3, 5'd3, 1'b1);
        step();
        for (int i = 0; i < 10; i++) step();
        check("rstbusy stall", {31'd0, ex_stall}, 32'd1);
        reset = 1'b1;
        apply(32'h404, 32'hFFF0_0293, 32'd0, 32'd0, 5'd5, 1'b1);
        step();
        reset = 1'b0;
        #1;
        check("rstbusy stall_after", {31'd0, ex_stall}, 32'd0);
        check("rstbusy iw_out", iw_out, C_TB_NOP);
        check("rstbusy alu_out", alu_out, 32'd0);
        step();
        check("rstbusy addi", alu_out, 32'hFFFF_FFFF);
        check("rstbusy addi_iw", iw_out, 32'hFFF0_0293);
`else
        // MUL without the M extension is a single-cycle bubble
        apply(32'h300, 32'h0220_81B3, 32'h0001_0000, 32'h0001_0000, 5'd3, 1'b1);
        #1;
        check("mul_nom stall", {31'd0, ex_stall}, 32'd0);
        check("mul_nom df_en", {31'd0, df_ex_enable}, 32'd0);
        step();
        check("mul_nom wb_en", {31'd0, wb_enable_out}, 32'd0);
        check("mul_nom alu_out", alu_out, 32'd0);
        check("mul_nom iw_out", iw_out, 32'h0220_81B3);
        check("mul_nom stall2", {31'd0, ex_stall}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rv32_ex_top.md
RV32_EX_TOP -- requirements
Module: rv32_ex_top

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk is the only clock, and reset is sampled on the rising clock edge.
REQ-002 SHALL have these ports, listed as name, direction, width, meaning:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- pc_in  in  32  PC from ID
- iw_in  in  32  instruction word from ID
- rs1_data_in  in  32  forwarded rs1 value
- rs2_data_in  in  32  forwarded rs2 value
- wb_reg_in  in  5  destination register
- wb_enable_in  in  1  writeback enable
- pc_out  out  32  registered to MEM
- iw_out  out  32  registered to MEM
- alu_out  out  32  registered result or address to MEM
- wb_reg_out  out  5  registered to MEM
- wb_enable_out  out  1  registered to MEM
- rs2_data_out  out  32  registered store data to MEM
- store_out  out  1  registered store flag to MEM (MEM wb_from_ex_mem)
- df_ex_enable  out  1  combinational forward valid to ID
- df_ex_reg  out  5  combinational forward register
- df_ex_data  out  32  combinational forward data
- ex_stall  out  1  combinational hold request to IF/ID

Function
REQ-003 SHALL compute alu_out from iw_in as follows:
- OP/OP-IMM: RV32I arithmetic; shift amount is bits [4:0].
- LUI: the immediate.
- AUIPC: pc + immediate.
- JAL/JALR: pc_in+4.
- LOAD/STORE: rs1 + sign-extended offset.
- BRANCH/SYSTEM/FENCE: 0.
REQ-004 SHALL register all MEM outputs on each rising edge when ex_stall=0, giving a single-cycle latency for non-M instructions.
REQ-005 SHALL drive store_out=1 exactly when the opcode is 0100011, and drive rs2_data_out from rs2_data_in unmodified.
REQ-006 SHALL drive df_ex_enable=wb_enable_in and ex_stall=0, df_ex_reg=wb_reg_in, and df_ex_data=the computed result; df_ex_enable SHALL be 0 for loads and for M-ops that are not in the DONE state.
REQ-007 SHALL treat M-ops (opcode 0110011, funct7 0000001) as multi-cycle through the state machine IDLE->BUSY->DONE->IDLE.
REQ-008 IDLE state: when an M-op is present, the block SHALL latch its operands, clear the counter, go to BUSY, and drive ex_stall=1.
REQ-009 BUSY state: the block SHALL run one radix-2 iteration per cycle with the counter counting 0..31, hold ex_stall=1, and go to DONE after counter=31.
REQ-010 DONE state: the block SHALL drive ex_stall=0 and present the result; the next edge registers the M-op into MEM and returns the state to IDLE.
REQ-011 M-op latency SHALL be as follows: ex_stall is high for exactly 33 cycles, and the result appears in alu_out after the 34th edge.
REQ-012 While ex_stall=1, the block SHALL emit a bubble to MEM each edge: iw_out=0x00000013, wb_enable_out=0, store_out=0, alu_out=0.
REQ-013 While ex_stall=1, the upstream SHALL hold all inputs stable; the block SHALL NOT re-sample operands until IDLE.
REQ-014 MUL, MULH, MULHSU and MULHU SHALL return the low or high word of the 64-bit product with the correct signedness; signed operands are negated to magnitude and the sign is fixed after the final iteration.
REQ-015 DIV, DIVU, REM and REMU SHALL use restoring division, with these boundary cases:
- Divide by zero: quotient=0xFFFFFFFF and remainder=the dividend.
- 0x80000000 / -1: quotient=0x80000000 and remainder=0.
REQ-016 The remainder sign SHALL follow the dividend.

Reset
REQ-017 Reset SHALL drive the MEM outputs as follows: pc_out=0, iw_out=0x00000013, alu_out=0, wb_reg_out=0, wb_enable_out=0, rs2_data_out=0, store_out=0.
REQ-018 Reset SHALL return the state machine to IDLE with counter=0 and ex_stall=0 in the next cycle, including when reset is asserted mid-BUSY; a partial result SHALL never reach MEM.

Configuration
REQ-019 Macro RV32M_EN defined: M-ops SHALL behave as specified in REQ-007 through REQ-016.
REQ-020 Macro RV32M_EN undefined: the multi-divide logic SHALL be absent, ex_stall SHALL be tied to 0, and M-ops SHALL pass as single-cycle bubbles (wb_enable_out=0, alu_out=0) with iw_out=the original instruction.

Structure
REQ-021 The shared package SHALL hold:
- the opcode constants (OP, OP_IMM, LUI, AUIPC, JAL, JALR, LOAD, STORE, BRANCH);
- the funct3 ALU codes;
- the M funct3 codes;
- NOP=0x00000013;
- the state-machine state encoding.
REQ-022 Multiply/divide SHALL be a sub-module, rv32_muldiv, with ports start, op[2:0], a, b, busy, done and result, compiled only under RV32M_EN.

Verification
REQ-023 ADDI x5,x0,-1 -> alu_out=0xFFFFFFFF one edge later, and df_ex_data=0xFFFFFFFF in the same cycle.
REQ-024 SW with rs1=0x1000, offset=8, rs2=0xCAFEBABE -> alu_out=0x1008, store_out=1, rs2_data_out=0xCAFEBABE, wb_enable_out=0.
REQ-025 MUL with 0x00010000 and 0x00010000 -> ex_stall high for 33 cycles, 33 bubbles, then alu_out=0, and MULHU gives 0x00000001.
REQ-026 DIV -7/2 -> quotient 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIV x/0 with x=5 -> 0xFFFFFFFF; REM x/0 -> 5; DIV 0x80000000/-1 -> 0x80000000.
REQ-027 Reset asserted on BUSY cycle 10 of a DIV -> the next cycle has ex_stall=0 and iw_out=0x13, and a following ADDI completes in one cycle.
REQ-028 With RV32M_EN undefined, MUL -> ex_stall stays 0, with wb_enable_out=0 and alu_out=0 after one edge.
